mult_seq_booth: RTL
===================

# mult_seq_booth

Parametrised sequential shift-add multiplier producing the full 2·NB_DATA-bit product of two NB_DATA-bit operands. Each operation selects signed (two's complement) or unsigned mode. A start/busy/valid handshake and an internal FSM replace free-running load/shift sequencing. It sits in the arithmetic datapath wherever area matters more than throughput, e.g. fixed-point filter taps and scaling stages.

## Interface
- NB_DATA, 8, operand width in bits; ≥ 2
- NB_FRAC, NB_DATA-1, fractional bits dropped by the optional fixed-point output; 0 ≤ NB_FRAC ≤ NB_DATA
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  request; sampled only in IDLE
- i_signed  in  1  1 = signed, 0 = unsigned; captured with i_start
- i_a  in  NB_DATA  multiplicand; captured with i_start
- i_b  in  NB_DATA  multiplier; captured with i_start
- o_busy  out  1  high in CALC and DONE
- o_valid  out  1  one-cycle pulse; o_product is new and valid
- o_product  out  2·NB_DATA  full product; held until the next o_valid
- o_mult_fx  out  NB_DATA  (MULT_FX_OUT_EN only) product >> NB_FRAC, saturated

## Operation
- States: IDLE → CALC (NB_DATA cycles, iteration counter 0..NB_DATA-1) → DONE (1 cycle) → IDLE.
- IDLE with i_start=1 loads:
  - reg_a ← i_a, extended to NB_DATA+1 bits (sign-extended if i_signed, zero-extended otherwise)
  - L ← i_b
  - H (NB_DATA+1 bits) ← 0
  - counter ← 0
- Each CALC cycle:
  - pp = L[0] ? reg_a : 0
  - sum = H ± pp, computed at NB_DATA+2 bits; subtract only on the last iteration in signed mode, add otherwise
  - {H, L} ← {sum, L} >> 1: arithmetic shift in signed mode, logical in unsigned; sum[0] enters L[MSB]
- Entering DONE: o_product ← {H[NB_DATA-1:0], L}; o_valid=1 for that cycle.
- i_start in CALC or DONE is ignored. Inputs are not re-sampled and no error is flagged.
- Operand edge cases must be exact: signed mode with both operands = most-negative value, and unsigned mode with all-ones operands.
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_product=0, o_mult_fx=0. Reset mid-operation aborts with no o_valid pulse.

## Timing
- i_start accepted at edge k. o_busy=1 from k+1. o_valid=1 during the cycle following edge k+NB_DATA.
- Latency is NB_DATA+1 cycles from start to valid.
- Back in IDLE after edge k+NB_DATA+1. Next accepted start is at edge k+NB_DATA+2 at the earliest, giving throughput of 1 product per NB_DATA+2 cycles.
- o_busy deasserts in the same cycle the FSM returns to IDLE. i_start may be held high continuously; each IDLE cycle starts a new operation.

## Configuration
- MULT_FX_OUT_EN defined:
  - o_mult_fx port and logic present
  - Value = o_product arithmetically (signed) or logically (unsigned) shifted right by NB_FRAC, then saturated to the NB_DATA-bit signed or unsigned range
  - Registered together with o_product
- Undefined: port and logic absent; o_product behaviour is identical.

## Structure
- Package mult_pkg:
  - state encoding (IDLE, CALC, DONE)
  - counter width function clog2(NB_DATA)
  - product width constant
- Sub-module mult_seq_ctrl:
  - FSM and iteration counter
  - Outputs: load, shift, last (drives the subtract select), busy, valid strobes
- Datapath (registers, adder/subtractor, output registers) lives in the top.

## Test plan
- NB_DATA=4, signed, a=7, b=-3 → o_product=8'hEB (-21); o_valid exactly 5 cycles after start.
- NB_DATA=4, signed, a=-8, b=-8 → 8'h40 (64). Unsigned, a=15, b=15 → 8'hE1 (225).
- Start at k, i_start pulsed again at k+2 with other operands → ignored; single valid with the first result.
- i_rst asserted in the 3rd CALC cycle → no o_valid, all outputs 0. Next start gives the correct result.
- MULT_FX_OUT_EN, NB_DATA=8, NB_FRAC=7, signed:
  - 0x40 × 0x40 (0.5 × 0.5) → o_mult_fx=0x20
  - 0x80 × 0x80 → saturates to 0x7F
- Random regression, 10k operations per mode, NB_DATA ∈ {4, 8, 16}, back-to-back starts, compared against a behavioural product model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// MULT_FX_OUT_EN enables the saturated fixed-point output in the top.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned prod_w(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl.sv
// Sequencer for mult_seq_booth: IDLE -> CALC (NB_DATA cycles) -> DONE.
// MULT_FX_OUT_EN does not affect this block.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned NB_DATA = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_load,
  output logic o_shift,
  output logic o_last,
  output logic o_busy,
  output logic o_valid
);

  localparam int unsigned CW = cnt_w(NB_DATA);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB_DATA - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_load  = 1'b0;
    o_shift = 1'b0;
    o_last  = 1'b0;
    o_busy  = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          o_load  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        o_busy  = 1'b1;
        o_shift = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          o_last  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mult_seq_booth.sv
// Sequential shift-add multiplier, signed or unsigned per operation.
// MULT_FX_OUT_EN adds o_mult_fx: product >> NB_FRAC, saturated.
module mult_seq_booth
  import mult_pkg::*;
#(
  parameter int unsigned NB_DATA = 8
`ifdef MULT_FX_OUT_EN
  ,
  parameter int unsigned NB_FRAC = NB_DATA - 1
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic [NB_DATA-1:0]   i_a,
  input  logic [NB_DATA-1:0]   i_b,
  output logic                 o_busy,
  output logic                 o_valid,
`ifdef MULT_FX_OUT_EN
  output logic [NB_DATA-1:0]   o_mult_fx,
`endif
  output logic [2*NB_DATA-1:0] o_product
);

  localparam int unsigned NP = prod_w(NB_DATA);

  logic load, shift, last;

  mult_seq_ctrl #(
    .NB_DATA(NB_DATA)
  ) u_ctrl (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .o_load (load),
    .o_shift(shift),
    .o_last (last),
    .o_busy (o_busy),
    .o_valid(o_valid)
  );

  logic [NB_DATA:0]   a_q, a_d;
  logic [NB_DATA:0]   h_q, h_d;
  logic [NB_DATA-1:0] l_q, l_d;
  logic               sgn_q, sgn_d;
  logic [NP-1:0]      prod_q, prod_d;

  logic [NB_DATA:0]   pp;
  logic [NB_DATA+1:0] h_x, pp_x, sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q    <= '0;
      h_q    <= '0;
      l_q    <= '0;
      sgn_q  <= 1'b0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      h_q    <= h_d;
      l_q    <= l_d;
      sgn_q  <= sgn_d;
      prod_q <= prod_d;
    end
  end

  always_comb begin
    pp   = l_q[0] ? a_q : '0;
    h_x  = {sgn_q & h_q[NB_DATA], h_q};
    pp_x = {sgn_q & pp[NB_DATA], pp};
    // The multiplier's sign bit carries weight -2^(N-1) in signed mode
    sum  = (sgn_q && last) ? h_x - pp_x : h_x + pp_x;

    a_d    = a_q;
    h_d    = h_q;
    l_d    = l_q;
    sgn_d  = sgn_q;
    prod_d = prod_q;
    if (load) begin
      a_d   = {i_signed & i_a[NB_DATA-1], i_a};
      h_d   = '0;
      l_d   = i_b;
      sgn_d = i_signed;
    end else if (shift) begin
      h_d = sum[NB_DATA+1:1];
      l_d = {sum[0], l_q[NB_DATA-1:1]};
    end
    if (last) begin
      prod_d = {sum[NB_DATA:0], l_q[NB_DATA-1:1]};
    end
  end

  assign o_product = prod_q;

`ifdef MULT_FX_OUT_EN
  logic [NB_DATA-1:0] fx_q, fx_d;
  logic signed [NP-1:0] shr_s;
  logic [NP-1:0]      shr_u, shr;
  logic               fits;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fx_q <= '0;
    end else begin
      fx_q <= fx_d;
    end
  end

  always_comb begin
    shr_s = $signed(prod_d) >>> NB_FRAC;
    shr_u = prod_d >> NB_FRAC;
    shr   = sgn_q ? NP'(shr_s) : shr_u;
    fits  = 1'b0;
    fx_d  = fx_q;
    if (sgn_q) begin
      fits = (&shr[NP-1:NB_DATA-1]) | ~(|shr[NP-1:NB_DATA-1]);
    end else begin
      fits = ~(|shr[NP-1:NB_DATA]);
    end
    if (last) begin
      unique case (1'b1)
        fits:   fx_d = shr[NB_DATA-1:0];
        !sgn_q: fx_d = '1;
        default: fx_d = shr[NP-1] ? {1'b1, {(NB_DATA-1){1'b0}}}
                                  : {1'b0, {(NB_DATA-1){1'b1}}};
      endcase
    end
  end

  assign o_mult_fx = fx_q;
`endif

endmodule
